// File: rtl/slave_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : slave_arb_pkg
// Description : Shared definitions for the two-master shared-slave arbiter.
//               Holds the grant select encodings driven into mux_slave, the
//               arbiter FSM state type and small helper functions. Imported
//               by the arbiter RTL and by mux_slave testbenches.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package slave_arb_pkg;

  // Grant select encodings seen by mux_slave.
  localparam logic [1:0] GNT_NONE   = 2'b00;
  localparam logic [1:0] GNT_FIRST  = 2'b10;
  localparam logic [1:0] GNT_SECOND = 2'b01;

  // Arbiter ownership state.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_OWN_FIRST  = 2'd1,
    ST_OWN_SECOND = 2'd2
  } arb_state_t;

  // Grant select that corresponds to an ownership state.
  function automatic logic [1:0] grant_of(input arb_state_t state);
    logic [1:0] g;
    g = GNT_NONE;
    case (state)
      ST_OWN_FIRST:  g = GNT_FIRST;
      ST_OWN_SECOND: g = GNT_SECOND;
      default:       g = GNT_NONE;
    endcase
    return g;
  endfunction

  // Watchdog counter width; a disabled watchdog (timeout 0) still needs a
  // legal, non-zero width wherever the value is used.
  function automatic int unsigned wd_width(input int unsigned timeout);
    return (timeout > 0) ? $clog2(timeout + 1) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/slave_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : slave_arbiter_if
// Description : Handshake bundle between the two masters / shared slave and
//               the arbiter.
//   req_first   : request from master first (held until acknowledged)
//   req_second  : request from master second (held until acknowledged)
//   ack         : single-cycle acknowledge from the shared slave
//   grant       : mux select, 10 = first, 01 = second, 00 = none
//   busy        : grant != 00
//   timeout_err : one-cycle pulse when the watchdog aborts a transaction
//   err_master  : master of the aborted transaction (0 first, 1 second)
// Modports    : master - the requesting side (masters + slave ack)
//               slave  - the arbiter itself
// Revision    : 1.0 - initial release
// ============================================================================
interface slave_arbiter_if;

  logic       req_first;
  logic       req_second;
  logic       ack;
  logic [1:0] grant;
  logic       busy;
  logic       timeout_err;
  logic       err_master;

  modport master (
    output req_first,
    output req_second,
    output ack,
    input  grant,
    input  busy,
    input  timeout_err,
    input  err_master
  );

  modport slave (
    input  req_first,
    input  req_second,
    input  ack,
    output grant,
    output busy,
    output timeout_err,
    output err_master
  );

endinterface
`default_nettype wire

// File: rtl/arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : arb_watchdog
// Description : Saturating transaction watchdog for slave_arbiter.
//               Counts enabled cycles since the last clear and flags the
//               cycle in which the count would reach TIMEOUT. Tied off when
//               TIMEOUT is 0.
// Ports       : clk     - clock
//               rst     - synchronous active-high reset
//               clear   - zero the count (takes priority over enable)
//               enable  - count this cycle
//               expired - the current enabled cycle is the TIMEOUT-th one
// Revision    : 1.0 - initial release
// ============================================================================
module arb_watchdog
  import slave_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_wd_off
      assign expired = 1'b0;
    end else begin : g_wd_on
      localparam int unsigned CW = wd_width(TIMEOUT);
      localparam logic [CW-1:0] C_MAX  = CW'(TIMEOUT);
      localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);
      localparam logic [CW-1:0] C_ONE  = CW'(1);

      logic [CW-1:0] r_count;

      // Saturates at TIMEOUT so a stalled abort can never wrap back to 0.
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          r_count <= '0;
        end else if (enable && (r_count != C_MAX)) begin
          r_count <= r_count + C_ONE;
        end
      end

      // Flagged one count early: the arbiter registers the error pulse on
      // this edge, so the pulse coincides with the count reaching TIMEOUT.
      assign expired = enable && (r_count == C_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : slave_arbiter
// Description : Two-master round-robin arbiter driving the grant select of
//               the shared-slave multiplexer. Holds ownership for a whole
//               req/ack transaction, hands off without a bubble on
//               completion, and aborts hung transactions via a watchdog.
// Parameters  : TIMEOUT - max cycles a granted transaction waits for ack
//                         (0 disables the watchdog)
// Ports       : clk - clock
//               rst - synchronous active-high reset
//               bus - slave_arbiter_if.slave (requests, ack, grant, busy,
//                     timeout_err, err_master)
// Revision    : 1.0 - initial release
// ============================================================================
module slave_arbiter
  import slave_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  slave_arbiter_if.slave bus
);

  arb_state_t r_state;
  logic       r_rr;          // 0: first has priority, 1: second has priority
  logic [1:0] r_grant;
  logic       r_timeout_err;
  logic       r_err_master;

  logic w_own_first;
  logic w_own_second;
  logic w_owned;
  logic w_req_owner;
  logic w_complete;
  logic w_abandon;
  logic w_leave;
  logic w_wd_clear;
  logic w_wd_enable;
  logic w_wd_expired;

  assign w_own_first  = (r_state == ST_OWN_FIRST);
  assign w_own_second = (r_state == ST_OWN_SECOND);
  assign w_owned      = w_own_first | w_own_second;

  // Request of whichever master currently owns the slave.
  assign w_req_owner  = (w_own_first  & bus.req_first) |
                        (w_own_second & bus.req_second);

  assign w_complete   = w_req_owner & bus.ack;
  // Owner's request low is an abandon, even if ack shows up with it.
  assign w_abandon    = w_owned & ~w_req_owner;
  // A registered timeout_err means this cycle is the committed abort cycle.
  assign w_leave      = w_complete | w_abandon | r_timeout_err;

  // Count only while ownership continues; clearing while idle or while
  // leaving guarantees a zero count on every state entry, handoffs included.
  assign w_wd_clear   = ~w_owned | w_leave;
  assign w_wd_enable  = w_owned & ~w_leave;

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_wd_clear),
    .enable  (w_wd_enable),
    .expired (w_wd_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_rr          <= 1'b0;
      r_grant       <= GNT_NONE;
      r_timeout_err <= 1'b0;
      r_err_master  <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          // ack while idle has no effect.
          if (bus.req_first && (!bus.req_second || !r_rr)) begin
            r_state <= ST_OWN_FIRST;
            r_grant <= GNT_FIRST;
          end else if (bus.req_second) begin
            r_state <= ST_OWN_SECOND;
            r_grant <= GNT_SECOND;
          end
        end

        ST_OWN_FIRST: begin
          if (r_timeout_err) begin
            // Abort already reported; the hung master loses priority.
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
            r_rr    <= 1'b1;
          end else if (w_complete) begin
            r_rr <= 1'b1;
            if (bus.req_second) begin
              r_state <= ST_OWN_SECOND;
              r_grant <= GNT_SECOND;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= GNT_NONE;
            end
          end else if (w_abandon) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_err_master  <= 1'b0;
          end
        end

        ST_OWN_SECOND: begin
          if (r_timeout_err) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
            r_rr    <= 1'b0;
          end else if (w_complete) begin
            r_rr <= 1'b0;
            if (bus.req_first) begin
              r_state <= ST_OWN_FIRST;
              r_grant <= GNT_FIRST;
            end else begin
              r_state <= ST_IDLE;
              r_grant <= GNT_NONE;
            end
          end else if (w_abandon) begin
            r_state <= ST_IDLE;
            r_grant <= GNT_NONE;
          end else if (w_wd_expired) begin
            r_timeout_err <= 1'b1;
            r_err_master  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_grant <= GNT_NONE;
        end
      endcase
    end
  end

  assign bus.grant       = r_grant;
  assign bus.busy        = |r_grant;
  assign bus.timeout_err = r_timeout_err;
  assign bus.err_master  = r_err_master;

endmodule
`default_nettype wire

// File: tb/tb_slave_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_arbiter
// Description : Self-checking bench for slave_arbiter (TIMEOUT = 8).
//               Each step drives one cycle of inputs and queues the outputs
//               expected in the following cycle; a monitor pops and compares.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_arbiter;
  import slave_arb_pkg::*;

  localparam int unsigned TIMEOUT = 8;

  typedef struct packed {
    logic [1:0] grant;
    logic       busy;
    logic       terr;
    logic       em;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  slave_arbiter_if bus ();

  slave_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs; queue the outputs expected after the edge.
  task automatic step(input logic r, input logic rf, input logic rs, input logic a,
                      input logic [1:0] g, input logic te, input logic em);
    exp_t e;
    @(negedge clk);
    rst            = r;
    bus.req_first  = rf;
    bus.req_second = rs;
    bus.ack        = a;
    e.grant = g;
    e.busy  = (g != 2'b00);
    e.terr  = te;
    e.em    = em;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every registered output once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("grant",       bus.grant,               e.grant);
        chk("busy",        {1'b0, bus.busy},        {1'b0, e.busy});
        chk("timeout_err", {1'b0, bus.timeout_err}, {1'b0, e.terr});
        chk("err_master",  {1'b0, bus.err_master},  {1'b0, e.em});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.req_first  = 1'b0;
    bus.req_second = 1'b0;
    bus.ack        = 1'b0;

    // Reset state
    step(1, 0, 0, 0, GNT_NONE, 0, 0);
    step(1, 0, 0, 0, GNT_NONE, 0, 0);

    // Single master: grant next cycle, released the cycle after ack (rr -> 1)
    step(0, 0, 0, 0, GNT_NONE,  0, 0);
    step(0, 1, 0, 0, GNT_FIRST, 0, 0);
    step(0, 1, 0, 0, GNT_FIRST, 0, 0);
    step(0, 1, 0, 0, GNT_FIRST, 0, 0);
    step(0, 1, 0, 1, GNT_NONE,  0, 0);
    step(0, 0, 0, 0, GNT_NONE,  0, 0);

    // Priority rotation: rr = 1, so a tie goes to second
    step(0, 1, 1, 0, GNT_SECOND, 0, 0);
    step(0, 1, 1, 1, GNT_FIRST,  0, 0);
    step(0, 1, 0, 1, GNT_NONE,   0, 0);
    step(0, 0, 0, 0, GNT_NONE,   0, 0);

    // Simultaneous requests after reset: first, then second, then first
    step(1, 0, 0, 0, GNT_NONE,   0, 0);
    step(0, 1, 1, 0, GNT_FIRST,  0, 0);
    step(0, 1, 1, 1, GNT_SECOND, 0, 0);
    step(0, 1, 1, 1, GNT_FIRST,  0, 0);
    step(0, 1, 0, 1, GNT_NONE,   0, 0);
    step(0, 0, 0, 0, GNT_NONE,   0, 0);

    // Watchdog: second hangs; pulse TIMEOUT cycles after grant, then release
    step(0, 0, 1, 0, GNT_SECOND, 0, 0);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, GNT_SECOND, 0, 0);
    step(0, 0, 1, 0, GNT_SECOND, 1, 1);
    step(0, 1, 1, 0, GNT_NONE,   0, 1);
    // Hung master lost priority: first wins the tie
    step(0, 1, 1, 0, GNT_FIRST,  0, 1);
    step(0, 1, 1, 1, GNT_SECOND, 0, 1);
    step(0, 0, 1, 1, GNT_NONE,   0, 1);
    step(0, 0, 0, 0, GNT_NONE,   0, 1);

    // Abandon and stray ack (rr = 0 here)
    step(0, 1, 0, 0, GNT_FIRST,  0, 1);
    step(0, 0, 0, 0, GNT_NONE,   0, 1);
    step(0, 0, 0, 1, GNT_NONE,   0, 1);
    step(0, 1, 1, 0, GNT_FIRST,  0, 1);
    step(0, 1, 1, 1, GNT_SECOND, 0, 1);
    // Second abandons: rr stays 1, so the next tie still goes to second
    step(0, 1, 0, 0, GNT_NONE,   0, 1);
    step(0, 1, 1, 0, GNT_SECOND, 0, 1);
    // ack with owner's request low is an abandon too
    step(0, 1, 0, 1, GNT_NONE,   0, 1);
    step(0, 1, 1, 0, GNT_SECOND, 0, 1);

    // Reset mid-transaction: grant drops, no error, priority back to first
    step(1, 1, 1, 0, GNT_NONE,  0, 0);
    step(0, 1, 1, 0, GNT_FIRST, 0, 0);
    step(0, 0, 0, 0, GNT_NONE,  0, 0);

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/slave_arbiter.md
# slave_arbiter

Two-master round-robin arbiter that drives the `grant` select of the shared-slave multiplexer (`mux_slave`). It watches both masters' requests and the slave's acknowledge, and holds grant for one master for a full req/ack transaction. It hands off fairly on completion and recovers from a hung slave via a watchdog timeout. The block is purely control: no address or data passes through it.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles a granted transaction may wait for `ack`. A value of 0 disables the watchdog.

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_first` in 1: request from master first; held until acknowledged.
- `req_second` in 1: request from master second; held until acknowledged.
- `ack` in 1: slave acknowledge, single-cycle pulse per transaction.
- `grant` out 2: `2'b10` selects first, `2'b01` selects second, `2'b00` means none. Registered.
- `busy` out 1: high when `grant != 2'b00`.
- `timeout_err` out 1: one-cycle pulse when the watchdog aborts a transaction.
- `err_master` out 1: identifies the master whose transaction timed out (0 = first, 1 = second). Valid while `timeout_err` is high; holds its value otherwise.

## Operation
- **FSM states:** IDLE, OWN_FIRST, OWN_SECOND. `grant` is a registered decode of the state: IDLE→00, OWN_FIRST→10, OWN_SECOND→01.
- **Priority pointer `rr`:** 0 = first has priority, 1 = second has priority. Reset value is 0.
- **IDLE:**
  - Only one request active → go to OWN of that master.
  - Both requests active → go to OWN of the master selected by `rr`.
  - No request → stay in IDLE.
- **OWN_X, completion:** `ack && req_X` in the same cycle completes the transaction.
  - Set `rr` to the other master.
  - Other master requesting → go directly to OWN_other.
  - Otherwise → go to IDLE.
- **OWN_X, abandon:** `req_X` low without `ack` is an abandon. Go to IDLE; `rr` is unchanged.
- **OWN_X, watchdog:** the counter increments on each OWN cycle without completion. When it reaches `TIMEOUT`:
  - pulse `timeout_err`, set `err_master` = X;
  - go to IDLE and set `rr` to the other master.
- **Watchdog counter:** cleared on every state entry, including OWN→OWN handoff. Width is `$clog2(TIMEOUT+1)`; the counter saturates and never wraps.
- **Ignored `ack`:** `ack` in IDLE is ignored. `ack` while the granted master's request is low is treated as an abandon.
- **Simultaneous completion and timeout:** completion wins. No error pulse is generated.
- **Reset values:** `grant`=00, `busy`=0, `timeout_err`=0, `err_master`=0, state IDLE, `rr`=0, counter 0.
- **Reset mid-transaction:** grant drops to 00 on the next edge. The in-flight transaction is lost without an error pulse.

## Timing
- **Request to grant:** request first seen in IDLE at cycle N → `grant` valid at N+1. The mux then presents the request to the slave at N+1 (the mux is combinational).
- **Ack to handoff:** `ack` at cycle N → new `grant` (other master, or 00) at N+1. There is no bubble when the other master is waiting.
- **Master obligations:** a master must hold `req` and its payload stable while granted until it sees `ack`. It must drop `req` the cycle after `ack` or re-request.
  - A re-request by the same master after completion goes through IDLE, giving a minimum 1-cycle gap.
- **Timeout timing:** grant at N with no ack → `timeout_err` high in cycle N+`TIMEOUT`; `grant`=00 at N+`TIMEOUT`+1.
- **Output registration:** all outputs are registered except `busy`, which is a combinational OR of the `grant` bits.

## Structure
- **Package `slave_arb_pkg`:**
  - grant encodings `GNT_NONE`=2'b00, `GNT_FIRST`=2'b10, `GNT_SECOND`=2'b01;
  - the FSM state enum;
  - shared with `mux_slave` testbenches.
- **Sub-module `arb_watchdog`:** parameterised saturating counter.
  - Inputs: `clear`, `enable`.
  - Output: `expired`.
  - Tied off when `TIMEOUT`=0.

## Test plan
1. **Single master:** reset, then `req_first`=1 at cycle 2 → `grant`=10 at cycle 3. `ack` at cycle 5 → `grant`=00 at cycle 6.
2. **Simultaneous requests after reset:** both requests at cycle 2 → `grant`=10 at 3. `ack` at 4 → `grant`=01 at 5. `ack` at 6 → `grant`=10 at 7 (alternates, no bubble).
3. **Priority rotation:** with `rr`=1 after one first-transaction, `req_second` and `req_first` both rise together → `grant`=01.
4. **Watchdog:** `TIMEOUT`=8, `req_second` held, no ack → `timeout_err` pulse 8 cycles after grant, `err_master`=1, `grant`=00 the next cycle. Then `req_first` is granted before `req_second`.
5. **Abandon and stray ack:** `req_first` drops while granted → `grant`=00 next cycle, `rr` unchanged. `ack` in IDLE → no state change.
6. **Reset mid-transaction:** `rst` pulsed while `grant`=01 → `grant`=00, `timeout_err`=0 next cycle. A subsequent simultaneous request is granted to first.
